// File: rtl/ram_march_bist.sv
`default_nettype none
// ============================================================================
// ram_march_bist : March C- self-test initiator for one single-port
//                  DFFRAM-style macro (EN / WE / Di / Do / A).
// Revision       : 1.0
// ============================================================================
module ram_march_bist #(
  parameter int unsigned AW = 12,
  parameter logic [31:0] P0 = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [31:0]   fail_data,
  output logic          EN,
  output logic [3:0]    WE,
  output logic [31:0]   Di,
  output logic [AW-1:0] A,
  input  logic [31:0]   Do
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_M0   = 4'd1,
    S_M1   = 4'd2,
    S_M2   = 4'd3,
    S_M3   = 4'd4,
    S_M4   = 4'd5,
    S_M5   = 4'd6,
    S_DONE = 4'd7
  } state_t;

  localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic          ph_q, ph_d;         // r,w elements: 1 while the write half is on the port
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [31:0]   fail_data_q, fail_data_d;
  logic          en_q, en_d;
  logic [3:0]    we_q, we_d;
  logic [31:0]   di_q, di_d;
  logic [AW-1:0] a_q, a_d;
  logic          rd_vld_q, rd_vld_d;
  logic [31:0]   rd_exp_q, rd_exp_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;

  logic          op_rd;
  logic          op_wr;
  logic [31:0]   wdata;
  logic [31:0]   exp_cur;
  logic          mism;

  // Reads in M2/M4 expect the inverted background, all others expect P0.
  assign exp_cur = ((state_q == S_M2) || (state_q == S_M4)) ? ~P0 : P0;
  assign mism    = busy_q && rd_vld_q && (Do != rd_exp_q);

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    a_d         = a_q;
    en_d        = 1'b0;
    we_d        = 4'h0;
    di_d        = 32'h0;
    op_rd       = 1'b0;
    op_wr       = 1'b0;
    wdata       = 32'h0;
    rd_vld_d    = busy_q && en_q && (we_q == 4'h0);
    rd_exp_d    = exp_cur;
    rd_addr_d   = a_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_M0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = ADDR_ZERO;
          fail_data_d = 32'h0;
          a_d         = ADDR_ZERO;
          ph_d        = 1'b0;
          op_wr       = 1'b1;
          wdata       = P0;
        end
      end

      S_M0: begin
        if (a_q == ADDR_LAST) begin
          state_d = S_M1;
          a_d     = ADDR_ZERO;
          ph_d    = 1'b0;
          op_rd   = 1'b1;
        end else begin
          a_d   = a_q + ADDR_ONE;
          op_wr = 1'b1;
          wdata = P0;
        end
      end

      S_M1, S_M2: begin
        if (!ph_q) begin
          ph_d  = 1'b1;
          op_wr = 1'b1;
          wdata = (state_q == S_M1) ? ~P0 : P0;
        end else if (a_q == ADDR_LAST) begin
          state_d = (state_q == S_M1) ? S_M2 : S_M3;
          a_d     = (state_q == S_M1) ? ADDR_ZERO : ADDR_LAST;
          ph_d    = 1'b0;
          op_rd   = 1'b1;
        end else begin
          a_d   = a_q + ADDR_ONE;
          ph_d  = 1'b0;
          op_rd = 1'b1;
        end
      end

      S_M3, S_M4: begin
        if (!ph_q) begin
          ph_d  = 1'b1;
          op_wr = 1'b1;
          wdata = (state_q == S_M3) ? ~P0 : P0;
        end else if (a_q == ADDR_ZERO) begin
          state_d = (state_q == S_M3) ? S_M4 : S_M5;
          a_d     = ADDR_LAST;
          ph_d    = 1'b0;
          op_rd   = 1'b1;
        end else begin
          a_d   = a_q - ADDR_ONE;
          ph_d  = 1'b0;
          op_rd = 1'b1;
        end
      end

      S_M5: begin
        // EN low here means the final read has issued and this is its compare edge.
        if (!en_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (a_q != ADDR_ZERO) begin
          a_d   = a_q - ADDR_ONE;
          op_rd = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // First mismatch freezes the result and stops issuing RAM operations.
    if (mism) begin
      state_d     = S_DONE;
      busy_d      = 1'b0;
      done_d      = 1'b1;
      fail_d      = 1'b1;
      fail_addr_d = rd_addr_q;
      fail_data_d = Do;
      a_d         = a_q;
      op_rd       = 1'b0;
      op_wr       = 1'b0;
    end

    if (op_wr) begin
      en_d = 1'b1;
      we_d = 4'hF;
      di_d = wdata;
    end else if (op_rd) begin
      en_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      ph_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= ADDR_ZERO;
      fail_data_q <= 32'h0;
      en_q        <= 1'b0;
      we_q        <= 4'h0;
      di_q        <= 32'h0;
      a_q         <= ADDR_ZERO;
      rd_vld_q    <= 1'b0;
      rd_exp_q    <= 32'h0;
      rd_addr_q   <= ADDR_ZERO;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      en_q        <= en_d;
      we_q        <= we_d;
      di_q        <= di_d;
      a_q         <= a_d;
      rd_vld_q    <= rd_vld_d;
      rd_exp_q    <= rd_exp_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign EN        = en_q;
  assign WE        = we_q;
  assign Di        = di_q;
  assign A         = a_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_march_bist.sv
`default_nettype none
// ============================================================================
// tb_ram_march_bist : bench for ram_march_bist with a behavioural 16-word RAM
//                     that can carry a stuck-at or an address-coupling fault.
// Revision          : 1.0
// ============================================================================
module tb_ram_march_bist;

  localparam int AW = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [31:0]   fail_data;
  logic          EN;
  logic [3:0]    WE;
  logic [31:0]   Di;
  logic [AW-1:0] A;
  logic [31:0]   Do;

  int checks   = 0;
  int failures = 0;

  int fault_mode = 0;  // 0 clean, 1 bit5 of word 7 stuck at 1, 2 write to word 3 also hits word 12
  logic [31:0] mem [N];

  always #5 clk = ~clk;

  ram_march_bist #(.AW(AW), .P0(32'h0000_0000)) dut (
    .CLK(clk), .RST(rst), .start(start), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr), .fail_data(fail_data),
    .EN(EN), .WE(WE), .Di(Di), .A(A), .Do(Do)
  );

  always @(posedge clk) begin
    if (EN) begin
      if (WE == 4'hF) begin
        mem[A] <= Di;
        if (fault_mode == 2 && A == 4'd3) mem[12] <= Di;
      end
      Do <= mem[A] | ((fault_mode == 1 && A == 4'd7) ? 32'h0000_0020 : 32'h0);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          fail;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            lat;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: pops one expected result per rising done and checks the in-run op sequence.
  bit          mon_en    = 1'b0;
  bit          seq_chk   = 1'b0;
  logic        busy_prev = 1'b0;
  logic        done_prev = 1'b0;
  int          acc_cyc   = 0;
  int          mon_i;
  int          mon_j;
  logic [3:0]  mon_a;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && !busy_prev) acc_cyc = cyc;
      mon_i = cyc - acc_cyc;
      if (seq_chk && busy) begin
        if (mon_i == 0)
          chk("first_op", 64'({EN, WE, A, Di}), 64'({1'b1, 4'hF, 4'h0, 32'h0}));
        if (mon_i >= 5*N && mon_i < 7*N) begin
          mon_j = mon_i - 5*N;
          mon_a = 4'(15 - mon_j/2);
          if (mon_j % 2 == 0)
            chk("m3_read", 64'({EN, WE, A, Di}), 64'({1'b1, 4'h0, mon_a, 32'h0}));
          else
            chk("m3_write", 64'({EN, WE, A, Di}), 64'({1'b1, 4'hF, mon_a, 32'hFFFF_FFFF}));
        end
        if (mon_i == 10*N)
          chk("drain_en", 64'(EN), 64'(0));
      end
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done rose with no expected result queued, required none");
        end else begin
          mon_e = sb_q.pop_front();
          chk("fail",         64'(fail),      64'(mon_e.fail));
          chk("fail_addr",    64'(fail_addr), 64'(mon_e.addr));
          chk("fail_data",    64'(fail_data), 64'(mon_e.data));
          chk("latency",      64'(mon_i),     64'(mon_e.lat));
          chk("busy_at_done", 64'(busy),      64'(0));
          chk("en_at_done",   64'(EN),        64'(0));
        end
      end
      busy_prev = busy;
      done_prev = done;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, n);
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_done"},      64'(done),      64'(0));
    chk({tag, "_fail"},      64'(fail),      64'(0));
    chk({tag, "_fail_addr"}, 64'(fail_addr), 64'(0));
    chk({tag, "_fail_data"}, 64'(fail_data), 64'(0));
    chk({tag, "_en"},        64'(EN),        64'(0));
    chk({tag, "_we"},        64'(WE),        64'(0));
    chk({tag, "_di"},        64'(Di),        64'(0));
    chk({tag, "_a"},         64'(A),         64'(0));
  endtask

  task automatic count_en(input int ncyc, output int hits);
    hits = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (EN) hits++;
    end
  endtask

  initial begin
    int en_hits;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Fault-free pass with op-sequence monitoring.
    seq_chk = 1'b1;
    sb_q.push_back('{1'b0, 4'd0, 32'h0, 161});
    pulse_start();
    chk("busy_after_accept", 64'(busy), 64'(1));
    wait_done(200, "pass");
    seq_chk = 1'b0;

    // Stuck-at-1 on bit 5 of word 7: caught by the M1 read of word 7.
    fault_mode = 1;
    sb_q.push_back('{1'b1, 4'd7, 32'h0000_0020, 32});
    pulse_start();
    wait_done(100, "stuck");
    count_en(5, en_hits);
    chk("en_after_fail", 64'(en_hits), 64'(0));

    // Restart from DONE clears the old failure; a start while busy is ignored.
    fault_mode = 0;
    sb_q.push_back('{1'b0, 4'd0, 32'h0, 161});
    pulse_start();
    chk("rerun_done_clr",      64'(done),      64'(0));
    chk("rerun_fail_clr",      64'(fail),      64'(0));
    chk("rerun_fail_addr_clr", 64'(fail_addr), 64'(0));
    chk("rerun_fail_data_clr", 64'(fail_data), 64'(0));
    chk("rerun_busy",          64'(busy),      64'(1));
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done(200, "rerun");

    // Write to word 3 also lands on word 12: M1 reads 12 back as ones.
    fault_mode = 2;
    sb_q.push_back('{1'b1, 4'd12, 32'hFFFF_FFFF, 42});
    pulse_start();
    wait_done(100, "coupling");

    // Reset at cycle 50 of a run, then a complete clean run.
    fault_mode = 0;
    pulse_start();
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrst");
    count_en(3, en_hits);
    chk("en_after_rst", 64'(en_hits), 64'(0));
    sb_q.push_back('{1'b0, 4'd0, 32'h0, 161});
    pulse_start();
    wait_done(200, "after_rst");

    // Reset and start together: reset wins.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 64'(busy), 64'(0));
    chk("rst_start_en",   64'(EN),   64'(0));
    chk("rst_start_done", 64'(done), 64'(0));
    count_en(3, en_hits);
    chk("rst_start_no_access", 64'(en_hits), 64'(0));

    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
